mem_copy_engine: RTL and testbench

Memory-side initiator that drives the DataMemory port (address, write data, MemRead, MemWrite) and consumes its registered read data. On a start pulse it copies a block of bytes from a source range to a destination range, one byte at a time. It also returns an 8-bit modulo-256 checksum of the bytes copied. It sits beside the datapath as a bus master, for block moves and memory self-test.

---
 rtl/mem_copy_engine.sv | 146 ++++++++++++++
 tb/tb_mem_copy_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: bus-master block copier for the DataMemory port.
// Copies `length` bytes from src to dst one byte at a time (read cycle,
// then write cycle). It also keeps a modulo-256 checksum of the bytes
// written. Addresses wrap modulo DEPTH. Length 0 completes at once, and
// length > DEPTH is rejected with an err pulse.
module mem_copy_engine #(
  parameter int DEPTH = 32,
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int LW    = 6
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [LW-1:0] length,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] sum,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata
);

  // DEPTH is a power of two, so wrapping an address is a simple mask.
  localparam logic [AW-1:0] AMASK   = AW'(DEPTH - 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] i_q, i_d;
  logic [DW-1:0] sum_q, sum_d;

  // State and captured transfer fields; reset clears everything at once.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      i_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      i_q     <= i_d;
      sum_q   <= sum_d;
    end
  end

  // Next-state logic and bus outputs. The outputs are decoded from the
  // current state, so a reset forces them low immediately.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    i_d       = i_q;
    sum_d     = sum_q;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length > DEPTH_L) begin
            // Rejected request: the previous checksum stays visible.
            state_d = S_ERR;
          end else if (length == '0) begin
            sum_d   = '0;
            state_d = S_DONE;
          end else begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            len_d   = length;
            i_d     = '0;
            sum_d   = '0;
            state_d = S_READ;
          end
        end
      end

      S_READ: begin
        busy     = 1'b1;
        mem_read = 1'b1;
        mem_addr = (src_q + AW'(i_q)) & AMASK;
        state_d  = S_WRITE;
      end

      S_WRITE: begin
        // Read data is still held from the previous cycle because
        // mem_read is low now, so pass it straight through.
        busy      = 1'b1;
        mem_write = 1'b1;
        mem_addr  = (dst_q + AW'(i_q)) & AMASK;
        mem_wdata = mem_rdata;
        sum_d     = sum_q + mem_rdata;
        i_d       = i_q + LW'(1);
        if (i_q + LW'(1) == len_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_READ;
        end
      end

      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end

      S_ERR: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign sum = sum_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine. The stimulus pushes the expected
// completion (pulse kind, cycle, checksum) for each request. A separate
// monitor pops an entry on every done/err pulse and compares it.
// A behavioural DataMemory with registered read sits on the bus.
module tb_mem_copy_engine;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0;
  logic [7:0] src_addr = '0;
  logic [7:0] dst_addr = '0;
  logic [5:0] length = '0;
  logic       busy, done, err;
  logic [7:0] sum, mem_addr, mem_wdata;
  logic       mem_read, mem_write;
  logic [7:0] mem_rdata = '0;

  mem_copy_engine #(.DEPTH(32), .AW(8), .DW(8), .LW(6)) dut (
    .clk       (clk),
    .RST       (RST),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .sum       (sum),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // DataMemory model: synchronous write, registered read.
  logic [7:0] mem [32];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[4:0]] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem[mem_addr[4:0]];
  end

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] sum;
    int         ecnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: strobe exclusivity on every access, scoreboard on every pulse.
  always @(negedge clk) begin
    if (mem_read) rd_cnt++;
    if (mem_write) wr_cnt++;
    if (mem_read || mem_write) check("strobe_excl", {31'd0, mem_read & mem_write}, 32'd0);
    if (done) done_cnt++;
    if (done || err) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, done, err}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("pulse_err",   {31'd0, err},  {31'd0, mon_e.is_err});
        check("pulse_done",  {31'd0, done}, {31'd0, !mon_e.is_err});
        check("pulse_cycle", ecnt, mon_e.ecnt);
        check("pulse_sum",   {24'd0, sum},  {24'd0, mon_e.sum});
        check("pulse_busy",  {31'd0, busy}, {31'd0, !mon_e.is_err});
        $display("pulse: %s sum=%02h cycle=%0d", err ? "err" : "done", sum, ecnt);
      end
    end
  end

  // Image: mem[i]=i below 28, then 0xF4..0xF1 in the top four bytes.
  task automatic load_image();
    for (int i = 0; i < 32; i++) mem[i] = (i < 28) ? 8'(i) : 8'(9'h110 - 9'(i));
  endtask

  task automatic issue(input logic [7:0] s, input logic [7:0] d, input logic [5:0] l,
                       input bit is_err, input logic [7:0] es, output int k);
    exp_t t;
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    length   = l;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = ecnt;
    t.is_err = is_err;
    t.sum    = es;
    t.ecnt   = (is_err || l == 0) ? k : k + 2 * int'(l);
    sb_q.push_back(t);
    $display("start: src=%0d dst=%0d len=%0d exp_sum=%02h exp_cycle=%0d", s, d, l, es, t.ecnt);
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sb_q.size() != 0; n++) @(negedge clk);
    check("drain", sb_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic chk_mem(input string name, input int a, input logic [7:0] exp);
    check(name, {24'd0, mem[a]}, {24'd0, exp});
  endtask

  initial begin
    int k, acc, d0, r0;
    load_image();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy",  {31'd0, busy}, 0);
    check("rst_done",  {31'd0, done}, 0);
    check("rst_err",   {31'd0, err}, 0);
    check("rst_strb",  {30'd0, mem_read, mem_write}, 0);
    check("rst_addr",  {24'd0, mem_addr}, 0);
    check("rst_sum",   {24'd0, sum}, 0);
    RST = 1'b0;

    // Basic copy 0 -> 16, four bytes, with busy window check
    issue(8'd0, 8'd16, 6'd4, 1'b0, 8'h06, k);
    for (int n = 0; n <= 9; n++) begin
      @(negedge clk);
      check("t1_busy", {31'd0, busy}, {31'd0, n <= 8});
    end
    drain();
    for (int i = 0; i < 4; i++) chk_mem("t1_mem", 16 + i, 8'(i));

    // Wrapping source; upper bit of dst is ignored (0x22 -> 2)
    load_image();
    issue(8'd30, 8'h22, 6'd4, 1'b0, 8'hE4, k);
    drain();
    chk_mem("t2_mem2", 2, 8'hF2);
    chk_mem("t2_mem3", 3, 8'hF1);
    chk_mem("t2_mem4", 4, 8'h00);
    chk_mem("t2_mem5", 5, 8'h01);

    // length > DEPTH: err only, no strobes, checksum retained
    acc = rd_cnt + wr_cnt;
    d0 = done_cnt;
    issue(8'd0, 8'd8, 6'd40, 1'b1, 8'hE4, k);
    drain();
    check("err_strobes", rd_cnt + wr_cnt - acc, 0);
    check("err_no_done", done_cnt - d0, 0);
    check("err_sum_kept", {24'd0, sum}, 32'hE4);

    // length == 0: done the cycle after start, no strobes, sum cleared
    acc = rd_cnt + wr_cnt;
    issue(8'd3, 8'd9, 6'd0, 1'b0, 8'h00, k);
    drain();
    check("len0_strobes", rd_cnt + wr_cnt - acc, 0);

    // Forward replication through overlapping ranges
    load_image();
    issue(8'd0, 8'd1, 6'd3, 1'b0, 8'h00, k);
    drain();
    for (int i = 1; i <= 3; i++) chk_mem("t3_mem", i, 8'h00);
    chk_mem("t3_mem4", 4, 8'h04);

    // Reset during the WRITE of byte 2 in an 8-byte copy
    load_image();
    issue(8'd0, 8'd16, 6'd8, 1'b0, 8'h00, k);
    for (int n = 0; n <= 5; n++) @(negedge clk);
    check("rm_in_write", {31'd0, mem_write}, 1);
    check("rm_waddr", {24'd0, mem_addr}, 18);
    RST = 1'b1;
    #1;
    sb_q.delete();
    check("rm_busy",  {31'd0, busy}, 0);
    check("rm_strb",  {30'd0, mem_read, mem_write}, 0);
    check("rm_addr",  {24'd0, mem_addr}, 0);
    check("rm_wdata", {24'd0, mem_wdata}, 0);
    check("rm_sum",   {24'd0, sum}, 0);
    @(negedge clk);
    RST = 1'b0;
    chk_mem("rm_mem16", 16, 8'h00);
    chk_mem("rm_mem17", 17, 8'h01);
    chk_mem("rm_mem18", 18, 8'd18);
    issue(8'd4, 8'd20, 6'd2, 1'b0, 8'h09, k);
    drain();
    chk_mem("rm_mem20", 20, 8'h04);
    chk_mem("rm_mem21", 21, 8'h05);

    // Starts while busy (cycle k+3) and in DONE (cycle k+9) are ignored
    load_image();
    d0 = done_cnt;
    r0 = rd_cnt;
    issue(8'd8, 8'd24, 6'd4, 1'b0, 8'h26, k);
    for (int n = 0; n <= 9; n++) begin
      @(negedge clk);
      if (n == 2 || n == 8) begin
        src_addr = 8'd0;
        dst_addr = 8'd0;
        length   = 6'd1;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    repeat (4) @(negedge clk);
    check("ign_one_done", done_cnt - d0, 1);
    check("ign_reads", rd_cnt - r0, 4);
    check("ign_idle", {31'd0, busy}, 0);
    for (int i = 0; i < 4; i++) chk_mem("ign_mem", 24 + i, 8'(8 + i));
    chk_mem("ign_mem0", 0, 8'h00);
    issue(8'd12, 8'd28, 6'd2, 1'b0, 8'h19, k);
    drain();
    chk_mem("ign_mem28", 28, 8'd12);
    chk_mem("ign_mem29", 29, 8'd13);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
